memory_stage: RTL and testbench
===============================

# memory_stage

Pipelined Y86-64 memory stage: the consumer of the execute stage's `valE`/`cnd` results. It registers execute results into the M pipeline register and performs the 8-byte little-endian data-memory read or write for the instruction held in M. It then registers the outcome into the W pipeline register for write-back. It also exports M-stage state to fetch (misprediction recovery) and to pipeline control (exception status).

## Interface
- `MEM_BYTES`, 1024: data-memory size in bytes; valid access requires `addr + 7 < MEM_BYTES`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `e_stat`  in  4  execute-stage status: AOK=1, HLT=2, ADR=3, INS=4.
- `e_icode`  in  4  execute-stage icode.
- `e_cnd`  in  1  condition result from execute.
- `e_valE`  in  64  ALU result from execute.
- `e_valA`  in  64  store data, pop/ret address, or fall-through PC.
- `e_dstE`, `e_dstM`  in  4 each  destination registers; 4'hF = none.
- `M_bubble`  in  1  load a bubble into M instead of execute results.
- `W_stall`  in  1  hold W unchanged.
- `M_icode`  out  4  M register icode.
- `M_cnd`  out  1  M register cnd, to fetch.
- `M_valA`  out  64  M register valA, to fetch.
- `m_stat`  out  4  combinational M-stage status after the address check.
- `m_valM`  out  64  combinational read data, for forwarding.
- `W_stat`, `W_icode`  out  4 each  W register.
- `W_valE`, `W_valM`  out  64 each  W register.
- `W_dstE`, `W_dstM`  out  4 each  W register.

## Operation
- Bubble value, used for M and W: stat=AOK, icode=NOP (4'h1), cnd=0, valE=valA=valM=0, dstE=dstM=4'hF.
- M capture at each edge:
  - `M_bubble`=1: load the bubble value.
  - otherwise: load the `e_*` inputs, except dstE is forced to 4'hF when `e_icode`=2 (cmovXX) and `e_cnd`=0.
- Address select, from the M register:
  - rmmovq(4), mrmovq(5), pushq(A), call(8): addr=valE.
  - popq(B), ret(9): addr=valA.
  - all other icodes: no access.
- Direction:
  - read: icode 5, B, 9.
  - write: icode 4, A, 8, with write data = valA.
- Little-endian: byte addr+i = data[8i+7:8i], for i = 0..7.
- `m_valM`: assembled bytes for a valid read; 0 otherwise.
- `m_stat`: ADR if an access is requested and `addr > MEM_BYTES-8` (unsigned 64-bit compare, no wrap); otherwise M stat.
- Write commits at the rising edge only when all of these hold: write requested, address valid, M stat = AOK, `W_stat` = AOK, and `rst` low.
- Writes never occur after an exception reaches W.
- W capture:
  - `W_stall`=1: hold W.
  - otherwise: W gets {m_stat, M icode, M valE, m_valM, M dstE, M dstM}.
- No FSM beyond the two registers; M and W each hold exactly one instruction.

## Timing
- Reset (asynchronous): M and W take the bubble value immediately. All outputs show the bubble/AOK values. Memory contents are unchanged by reset.
- Execute → M: 1 cycle. M → W: 1 cycle. Total latency from `e_*` to `W_*` is 2 edges.
- `m_valM` and `m_stat` are valid in the same cycle the instruction sits in M.
- A store at edge N is visible to a load that is in M during cycle N+1 (read-after-write through memory, no bypass).
- Simultaneous `M_bubble` and `W_stall`: M bubbles and W holds, so the instruction that was in M is lost. Pipeline control must not assert both at once; the block does not check this.
- Reset asserted mid-write cycle: the write is suppressed; M and W clear asynchronously.
- Address boundary:
  - addr = MEM_BYTES-8 is valid.
  - addr = MEM_BYTES-7 is ADR.
  - addr = 64'hFFFF_FFFF_FFFF_FFF8 is ADR; sum overflow must not wrap to valid.

## Test plan
- rmmovq: e_icode=4, e_valE=0x100, e_valA=0x1122334455667788 → byte 0x100 = 0x88 and byte 0x107 = 0x11. Then mrmovq from 0x100 with dstM=3 → W_valM=0x1122334455667788 and W_dstM=3, 2 cycles after issue.
- cmov not taken: e_icode=2, e_cnd=0, e_dstE=5 → M_dstE and W_dstE = 0xF. Repeat with e_cnd=1 → W_dstE=5.
- ADR boundary with MEM_BYTES=1024:
  - mrmovq addr 1016 → m_stat=AOK.
  - addr 1017 → m_stat=ADR and W_stat=3.
  - rmmovq to 1017 → memory unchanged.
- Write after exception: W_stat=ADR while pushq (icode A) is in M with valid addr 0x200 → byte 0x200 unchanged.
- Control:
  - M_bubble=1 for one cycle → W_icode=1 and W_stat=1 two cycles later.
  - W_stall=1 for 3 cycles → W outputs constant.
- Asynchronous reset pulse between edges while rmmovq is in M → outputs go to bubble values without a clock edge; the target bytes are not written.

Source files
------------

// File: rtl/memory_stage_if.sv
// Execute-to-memory-stage bundle: execute results and pipeline control in,
// M/W register state and M-stage combinational results out.
interface memory_stage_if;
  logic [3:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic        M_bubble;
  logic        W_stall;

  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  m_stat;
  logic [63:0] m_valM;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  modport master (
    output e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, M_bubble, W_stall,
    input  M_icode, M_cnd, M_valA, m_stat, m_valM,
           W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );

  modport slave (
    input  e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, M_bubble, W_stall,
    output M_icode, M_cnd, M_valA, m_stat, m_valM,
           W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 pipelined memory stage: M register, 8-byte little-endian data memory
// access for the instruction in M, and the W register feeding write-back.
module memory_stage #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic           clk,
  input logic           rst,
  memory_stage_if.slave bus
);
  localparam int unsigned AW      = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_ADR = 4'h3;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } m_reg_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_reg_t;

  localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0, valE: '0,
                                  valA: '0, dstE: REG_NONE, dstM: REG_NONE};
  localparam w_reg_t W_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, valE: '0, valM: '0,
                                  dstE: REG_NONE, dstM: REG_NONE};

  m_reg_t      m_q, m_d;
  w_reg_t      w_q, w_d;
  logic [7:0]  mem_q [MEM_BYTES];

  logic [63:0] mem_addr;
  logic        rd_req, wr_req, addr_ok, wr_en;
  logic [AW-1:0] base;
  logic [3:0]  m_stat;
  logic [63:0] m_valM;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    m_d = M_BUBBLE;
    if (!bus.M_bubble) begin
      m_d.stat  = bus.e_stat;
      m_d.icode = bus.e_icode;
      m_d.cnd   = bus.e_cnd;
      m_d.valE  = bus.e_valE;
      m_d.valA  = bus.e_valA;
      m_d.dstE  = (bus.e_icode == I_CMOV && !bus.e_cnd) ? REG_NONE : bus.e_dstE;
      m_d.dstM  = bus.e_dstM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) m_q <= M_BUBBLE;
    else     m_q <= m_d;
  end

  always_comb begin
    mem_addr = '0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    unique case (m_q.icode)
      I_RMMOVQ, I_PUSHQ, I_CALL: begin mem_addr = m_q.valE; wr_req = 1'b1; end
      I_MRMOVQ:                  begin mem_addr = m_q.valE; rd_req = 1'b1; end
      I_POPQ, I_RET:             begin mem_addr = m_q.valA; rd_req = 1'b1; end
      default: ;
    endcase
  end

  // Plain compare against MEM_BYTES-8 so huge addresses cannot wrap into range.
  assign addr_ok = (mem_addr <= ADDR_MAX);
  assign base    = mem_addr[AW-1:0];
  assign m_stat  = ((rd_req || wr_req) && !addr_ok) ? STAT_ADR : m_q.stat;
  assign wr_en   = wr_req && addr_ok && (m_q.stat == STAT_AOK) &&
                   (w_q.stat == STAT_AOK) && !rst;

  always_comb begin
    m_valM = '0;
    if (rd_req && addr_ok)
      for (int i = 0; i < 8; i++) m_valM[8*i +: 8] = mem_q[base + AW'(i)];
  end

  // NOTE: the data memory is deliberately not reset; reset must leave contents intact.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < 8; i++) mem_q[base + AW'(i)] <= m_q.valA[8*i +: 8];
  end

  always_comb begin
    w_d = '{stat: m_stat, icode: m_q.icode, valE: m_q.valE, valM: m_valM,
            dstE: m_q.dstE, dstM: m_q.dstM};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               w_q <= W_BUBBLE;
    else if (!bus.W_stall) w_q <= w_d;
  end

  assign bus.M_icode = m_q.icode;
  assign bus.M_cnd   = m_q.cnd;
  assign bus.M_valA  = m_q.valA;
  assign bus.m_stat  = m_stat;
  assign bus.m_valM  = m_valM;
  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_valE  = w_q.valE;
  assign bus.W_valM  = w_q.valM;
  assign bus.W_dstE  = w_q.dstE;
  assign bus.W_dstM  = w_q.dstM;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a vector table for single instructions plus
// hand sequences for write-after-exception, bubble, stall and async reset.
module tb_memory_stage;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  memory_stage_if bus ();
  memory_stage #(.MEM_BYTES(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  exp_stat;
    logic [63:0] exp_valM;
    logic [3:0]  exp_dstE;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] st, input logic [3:0] ic, input logic c,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    bus.e_stat  = st;
    bus.e_icode = ic;
    bus.e_cnd   = c;
    bus.e_valE  = ve;
    bus.e_valA  = va;
    bus.e_dstE  = de;
    bus.e_dstM  = dm;
  endtask

  task automatic nop();
    issue(4'h1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
  endtask

  function automatic logic [63:0] mem_word(input int a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = dut.mem_q[a + i];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          stat  ic    c  valE                    valA                    dstE  dstM  estat exp_valM                exp_dstE
    vecs[0]  = '{4'h1, 4'h4, 0, 64'h100,                64'h1122334455667788,  4'hF, 4'hF, 4'h1, 64'h0,                  4'hF};
    vecs[1]  = '{4'h1, 4'h5, 0, 64'h100,                64'h0,                 4'hF, 4'h3, 4'h1, 64'h1122334455667788,  4'hF};
    vecs[2]  = '{4'h1, 4'h2, 0, 64'h2A,                 64'h0,                 4'h5, 4'hF, 4'h1, 64'h0,                  4'hF};
    vecs[3]  = '{4'h1, 4'h2, 1, 64'h2B,                 64'h0,                 4'h5, 4'hF, 4'h1, 64'h0,                  4'h5};
    vecs[4]  = '{4'h1, 4'h4, 0, 64'd1016,               64'hA5A5_5A5A_0F0F_F0F0, 4'hF, 4'hF, 4'h1, 64'h0,                4'hF};
    vecs[5]  = '{4'h1, 4'h5, 0, 64'd1016,               64'h0,                 4'hF, 4'h2, 4'h1, 64'hA5A5_5A5A_0F0F_F0F0, 4'hF};
    vecs[6]  = '{4'h1, 4'h5, 0, 64'd1017,               64'h0,                 4'hF, 4'h2, 4'h3, 64'h0,                  4'hF};
    vecs[7]  = '{4'h1, 4'h4, 0, 64'd1017,               64'hDEAD_BEEF_DEAD_BEEF, 4'hF, 4'hF, 4'h3, 64'h0,                4'hF};
    vecs[8]  = '{4'h1, 4'h5, 0, 64'd1016,               64'h0,                 4'hF, 4'h2, 4'h1, 64'hA5A5_5A5A_0F0F_F0F0, 4'hF};
    vecs[9]  = '{4'h1, 4'h5, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                4'hF, 4'h2, 4'h3, 64'h0,                  4'hF};
    vecs[10] = '{4'h1, 4'hA, 0, 64'h200,                64'h0102030405060708,  4'h4, 4'hF, 4'h1, 64'h0,                  4'h4};
    vecs[11] = '{4'h1, 4'hB, 0, 64'h208,                64'h200,               4'h4, 4'h6, 4'h1, 64'h0102030405060708,  4'h4};
    vecs[12] = '{4'h1, 4'h9, 0, 64'h108,                64'h100,               4'h4, 4'hF, 4'h1, 64'h1122334455667788,  4'h4};
    vecs[13] = '{4'h1, 4'h8, 0, 64'h300,                64'h77,                4'h4, 4'hF, 4'h1, 64'h0,                  4'h4};
    vecs[14] = '{4'h1, 4'h5, 0, 64'h300,                64'h0,                 4'hF, 4'h1, 4'h1, 64'h77,                 4'hF};
    vecs[15] = '{4'h1, 4'h6, 1, 64'h55,                 64'h100,               4'h7, 4'hF, 4'h1, 64'h0,                  4'h7};
    vecs[16] = '{4'h2, 4'h0, 0, 64'h0,                  64'h0,                 4'hF, 4'hF, 4'h2, 64'h0,                  4'hF};

    bus.M_bubble = 1'b0;
    bus.W_stall  = 1'b0;
    nop();
    rst = 1'b1;
    #12;
    check("rst M_icode", 64'(bus.M_icode), 64'h1);
    check("rst m_stat",  64'(bus.m_stat),  64'h1);
    check("rst W_stat",  64'(bus.W_stat),  64'h1);
    check("rst W_icode", 64'(bus.W_icode), 64'h1);
    check("rst W_dstE",  64'(bus.W_dstE),  64'hF);
    check("rst W_dstM",  64'(bus.W_dstM),  64'hF);
    check("rst W_valE",  bus.W_valE,       64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      issue(vecs[i].stat, vecs[i].icode, vecs[i].cnd, vecs[i].valE, vecs[i].valA,
            vecs[i].dstE, vecs[i].dstM);
      step();
      check($sformatf("v%0d m_stat", i),  64'(bus.m_stat),  64'(vecs[i].exp_stat));
      check($sformatf("v%0d m_valM", i),  bus.m_valM,       vecs[i].exp_valM);
      check($sformatf("v%0d M_icode", i), 64'(bus.M_icode), 64'(vecs[i].icode));
      check($sformatf("v%0d M_cnd", i),   64'(bus.M_cnd),   64'(vecs[i].cnd));
      check($sformatf("v%0d M_valA", i),  bus.M_valA,       vecs[i].valA);
      nop();
      step();
      check($sformatf("v%0d W_stat", i),  64'(bus.W_stat),  64'(vecs[i].exp_stat));
      check($sformatf("v%0d W_icode", i), 64'(bus.W_icode), 64'(vecs[i].icode));
      check($sformatf("v%0d W_valE", i),  bus.W_valE,       vecs[i].valE);
      check($sformatf("v%0d W_valM", i),  bus.W_valM,       vecs[i].exp_valM);
      check($sformatf("v%0d W_dstE", i),  64'(bus.W_dstE),  64'(vecs[i].exp_dstE));
      check($sformatf("v%0d W_dstM", i),  64'(bus.W_dstM),  64'(vecs[i].dstM));
      if (i == 0) begin
        check("mem[0x100]", 64'(dut.mem_q[256]), 64'h88);
        check("mem[0x107]", 64'(dut.mem_q[263]), 64'h11);
      end
    end

    // pushq in M while an ADR load sits in W: the store must be dropped
    issue(4'h1, 4'h5, 1'b0, 64'd1017, 64'h0, 4'hF, 4'h2);
    step();
    issue(4'h1, 4'hA, 1'b0, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 4'h4, 4'hF);
    step();
    check("exc W_stat", 64'(bus.W_stat), 64'h3);
    check("exc M_icode", 64'(bus.M_icode), 64'hA);
    nop();
    step();
    step();
    check("exc mem[0x200]", mem_word(512), 64'h0102030405060708);

    // one-cycle bubble replaces the instruction entering M
    issue(4'h1, 4'h6, 1'b1, 64'h99, 64'h44, 4'h3, 4'hF);
    bus.M_bubble = 1'b1;
    step();
    bus.M_bubble = 1'b0;
    nop();
    check("bub M_icode", 64'(bus.M_icode), 64'h1);
    check("bub M_valA",  bus.M_valA,       64'h0);
    step();
    check("bub W_icode", 64'(bus.W_icode), 64'h1);
    check("bub W_stat",  64'(bus.W_stat),  64'h1);
    check("bub W_valE",  bus.W_valE,       64'h0);

    // W stall holds W for three edges while M keeps flowing
    issue(4'h1, 4'h6, 1'b1, 64'h1234, 64'h0, 4'h7, 4'hF);
    step();
    nop();
    step();
    bus.W_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(4'h1, 4'h6, 1'b1, 64'(k + 64'h500), 64'h0, 4'h2, 4'hF);
      step();
      check($sformatf("stall%0d W_valE", k),  bus.W_valE,       64'h1234);
      check($sformatf("stall%0d W_dstE", k),  64'(bus.W_dstE),  64'h7);
      check($sformatf("stall%0d W_icode", k), 64'(bus.W_icode), 64'h6);
    end
    bus.W_stall = 1'b0;
    nop();
    step();
    check("unstall W_valE", bus.W_valE, 64'h502);
    step();

    // async reset between edges while a store sits in M
    issue(4'h1, 4'h4, 1'b0, 64'h280, 64'h1111_1111_1111_1111, 4'hF, 4'hF);
    step();
    nop();
    step();
    check("pre mem[0x280]", mem_word(640), 64'h1111_1111_1111_1111);
    issue(4'h1, 4'h4, 1'b0, 64'h280, 64'hCAFE_F00D_CAFE_F00D, 4'hF, 4'hF);
    step();
    nop();
    check("arst pre M_icode", 64'(bus.M_icode), 64'h4);
    #2;
    rst = 1'b1;
    #1;
    check("arst M_icode", 64'(bus.M_icode), 64'h1);
    check("arst M_valA",  bus.M_valA,       64'h0);
    check("arst m_stat",  64'(bus.m_stat),  64'h1);
    check("arst W_icode", 64'(bus.W_icode), 64'h1);
    check("arst W_stat",  64'(bus.W_stat),  64'h1);
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    check("arst mem[0x280]", mem_word(640), 64'h1111_1111_1111_1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
